aleb_seq_cmp: RTL and testbench

//  Multi-cycle parametrised A<=B magnitude comparator with carry-in. Generalises the 2-bit LE carry slice.

---
 rtl/aleb_seq_cmp_if.sv | 22 ++
 rtl/aleb_seq_cmp.sv | 149 ++++++++++++++
 tb/tb_aleb_seq_cmp.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/aleb_seq_cmp_if.sv
// Handshake and operand bundle for aleb_seq_cmp.
// The eq signal exists only when ALEB_SEQ_EQ_EN is defined.
interface aleb_seq_cmp_if #(
  parameter int WIDTH = 16
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             busy;
  logic             done;
  logic             le;
`ifdef ALEB_SEQ_EQ_EN
  logic             eq;

  modport master (output start, a, b, ci, input busy, done, le, eq);
  modport slave  (input start, a, b, ci, output busy, done, le, eq);
`else
  modport master (output start, a, b, ci, input busy, done, le);
  modport slave  (input start, a, b, ci, output busy, done, le);
`endif
endinterface

// File: rtl/aleb_seq_cmp.sv
// Multi-cycle A<=B comparator: WIDTH-bit operands resolved LSB-first, SLICE bits per clock.
// Optional A==B output enabled by defining ALEB_SEQ_EQ_EN.
//
// state | meaning
// IDLE  | waiting for start; le/eq hold the last result
// RUN   | carry chain advancing one slice per clock
module aleb_seq_cmp #(
  parameter int WIDTH  = 16,
  parameter int SLICE  = 2,
  parameter int SIGNED = 0
) (
  input logic          clk,
  input logic          rst,
  aleb_seq_cmp_if.slave bus
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  // Flipping the MSB maps two's-complement onto offset-binary, so the unsigned chain yields a signed compare.
  localparam logic [WIDTH-1:0] SIGN_FLIP = (SIGNED != 0) ? (WIDTH'(1) << (WIDTH - 1)) : '0;

  if ((SLICE < 1) || (SLICE > WIDTH) || ((WIDTH % SLICE) != 0)) begin : g_bad_param
    $error("aleb_seq_cmp: WIDTH must be a multiple of SLICE, with 1 <= SLICE <= WIDTH");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             le_q, le_d;
`ifdef ALEB_SEQ_EQ_EN
  logic             eq_acc_q, eq_acc_d;
  logic             eq_q, eq_d;
  logic             slice_eq;
`endif

  logic accept;
  logic last;
  logic chain_c;

  assign accept = (state_q == IDLE) && bus.start;
  assign last   = (cnt_q == CW'(N - 1));

  always_comb begin
    chain_c = carry_q;
    for (int i = 0; i < SLICE; i++) begin
      chain_c = (~a_q[i] & b_q[i]) | (~a_q[i] & chain_c) | (b_q[i] & chain_c);
    end
  end

`ifdef ALEB_SEQ_EQ_EN
  assign slice_eq = (a_q[SLICE-1:0] == b_q[SLICE-1:0]);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last)      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == RUN);
    bus.done = done_q;
    bus.le   = le_q;
`ifdef ALEB_SEQ_EQ_EN
    bus.eq   = eq_q;
`endif
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    le_d    = le_q;
`ifdef ALEB_SEQ_EQ_EN
    eq_acc_d = eq_acc_q;
    eq_d     = eq_q;
`endif
    if (accept) begin
      a_d     = bus.a ^ SIGN_FLIP;
      b_d     = bus.b ^ SIGN_FLIP;
      carry_d = bus.ci;
      cnt_d   = '0;
      le_d    = 1'b0;
`ifdef ALEB_SEQ_EQ_EN
      eq_acc_d = 1'b1;
`endif
    end else if (state_q == RUN) begin
      a_d     = a_q >> SLICE;
      b_d     = b_q >> SLICE;
      carry_d = chain_c;
      cnt_d   = cnt_q + CW'(1);
`ifdef ALEB_SEQ_EQ_EN
      eq_acc_d = eq_acc_q & slice_eq;
`endif
      if (last) begin
        le_d   = chain_c;
        done_d = 1'b1;
`ifdef ALEB_SEQ_EQ_EN
        eq_d   = eq_acc_q & slice_eq;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      le_q    <= 1'b0;
`ifdef ALEB_SEQ_EQ_EN
      eq_acc_q <= 1'b0;
      eq_q     <= 1'b0;
`endif
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      le_q    <= le_d;
`ifdef ALEB_SEQ_EQ_EN
      eq_acc_q <= eq_acc_d;
      eq_q     <= eq_d;
`endif
    end
  end

endmodule

// File: tb/tb_aleb_seq_cmp.sv
// Randomised self-checking bench for aleb_seq_cmp across several WIDTH/SLICE/SIGNED builds.
// EQ is checked only when ALEB_SEQ_EQ_EN is defined.
module tb_aleb_seq_cmp;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  aleb_seq_cmp_if #(.WIDTH(2))  if_w2 ();
  aleb_seq_cmp_if #(.WIDTH(16)) if_u16 ();
  aleb_seq_cmp_if #(.WIDTH(16)) if_s16 ();
  aleb_seq_cmp_if #(.WIDTH(32)) if_s1 ();
  aleb_seq_cmp_if #(.WIDTH(32)) if_s4 ();
  aleb_seq_cmp_if #(.WIDTH(32)) if_s8 ();
  aleb_seq_cmp_if #(.WIDTH(32)) if_s32 ();

  aleb_seq_cmp #(.WIDTH(2),  .SLICE(2),  .SIGNED(0)) u_w2  (.clk(clk), .rst(rst), .bus(if_w2.slave));
  aleb_seq_cmp #(.WIDTH(16), .SLICE(2),  .SIGNED(0)) u_u16 (.clk(clk), .rst(rst), .bus(if_u16.slave));
  aleb_seq_cmp #(.WIDTH(16), .SLICE(2),  .SIGNED(1)) u_s16 (.clk(clk), .rst(rst), .bus(if_s16.slave));
  aleb_seq_cmp #(.WIDTH(32), .SLICE(1),  .SIGNED(0)) u_s1  (.clk(clk), .rst(rst), .bus(if_s1.slave));
  aleb_seq_cmp #(.WIDTH(32), .SLICE(4),  .SIGNED(0)) u_s4  (.clk(clk), .rst(rst), .bus(if_s4.slave));
  aleb_seq_cmp #(.WIDTH(32), .SLICE(8),  .SIGNED(1)) u_s8  (.clk(clk), .rst(rst), .bus(if_s8.slave));
  aleb_seq_cmp #(.WIDTH(32), .SLICE(32), .SIGNED(0)) u_s32 (.clk(clk), .rst(rst), .bus(if_s32.slave));

  logic        st2, ci2, st16, ci16, st32, ci32;
  logic [1:0]  a2, b2;
  logic [15:0] a16, b16;
  logic [31:0] a32, b32;

  assign if_w2.start  = st2;  assign if_w2.a  = a2;  assign if_w2.b  = b2;  assign if_w2.ci  = ci2;
  assign if_u16.start = st16; assign if_u16.a = a16; assign if_u16.b = b16; assign if_u16.ci = ci16;
  assign if_s16.start = st16; assign if_s16.a = a16; assign if_s16.b = b16; assign if_s16.ci = ci16;
  assign if_s1.start  = st32; assign if_s1.a  = a32; assign if_s1.b  = b32; assign if_s1.ci  = ci32;
  assign if_s4.start  = st32; assign if_s4.a  = a32; assign if_s4.b  = b32; assign if_s4.ci  = ci32;
  assign if_s8.start  = st32; assign if_s8.a  = a32; assign if_s8.b  = b32; assign if_s8.ci  = ci32;
  assign if_s32.start = st32; assign if_s32.a = a32; assign if_s32.b = b32; assign if_s32.ci = ci32;

  // Group g collects the DUTs that share one set of stimulus signals.
  logic [3:0] done_g [3];
  logic [3:0] busy_g [3];
  logic [3:0] le_g   [3];
  assign done_g[0] = {3'b000, if_w2.done};
  assign done_g[1] = {2'b00, if_s16.done, if_u16.done};
  assign done_g[2] = {if_s32.done, if_s8.done, if_s4.done, if_s1.done};
  assign busy_g[0] = {3'b000, if_w2.busy};
  assign busy_g[1] = {2'b00, if_s16.busy, if_u16.busy};
  assign busy_g[2] = {if_s32.busy, if_s8.busy, if_s4.busy, if_s1.busy};
  assign le_g[0]   = {3'b000, if_w2.le};
  assign le_g[1]   = {2'b00, if_s16.le, if_u16.le};
  assign le_g[2]   = {if_s32.le, if_s8.le, if_s4.le, if_s1.le};
`ifdef ALEB_SEQ_EQ_EN
  logic [3:0] eq_g [3];
  assign eq_g[0] = {3'b000, if_w2.eq};
  assign eq_g[1] = {2'b00, if_s16.eq, if_u16.eq};
  assign eq_g[2] = {if_s32.eq, if_s8.eq, if_s4.eq, if_s1.eq};
`endif

  int ndut [3]    = '{1, 2, 4};
  int wid  [3]    = '{2, 16, 32};
  int ncyc [3][4] = '{'{1, 0, 0, 0}, '{8, 8, 0, 0}, '{32, 8, 4, 1}};
  int sgn  [3][4] = '{'{0, 0, 0, 0}, '{0, 1, 0, 0}, '{0, 0, 1, 0}};

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wmask(int w);
    logic [31:0] m;
    m = 32'hFFFF_FFFF >> (32 - w);
    return m;
  endfunction

  function automatic longint value_of(int w, int s, logic [31:0] x);
    longint v;
    v = longint'({32'h0, x & wmask(w)});
    if (s != 0 && x[w-1]) v = v - (longint'(1) << w);
    return v;
  endfunction

  function automatic logic ref_le(int w, int s, logic [31:0] a, logic [31:0] b, logic ci);
    longint va, vb;
    va = value_of(w, s, a);
    vb = value_of(w, s, b);
    return ci ? (va <= vb) : (va < vb);
  endfunction

  function automatic logic ref_eq(int w, logic [31:0] a, logic [31:0] b);
    return (a & wmask(w)) == (b & wmask(w));
  endfunction

  task automatic drive(int g, logic st, logic [31:0] a, logic [31:0] b, logic ci);
    case (g)
      0:       begin st2  = st; a2  = a[1:0];  b2  = b[1:0];  ci2  = ci; end
      1:       begin st16 = st; a16 = a[15:0]; b16 = b[15:0]; ci16 = ci; end
      default: begin st32 = st; a32 = a;       b32 = b;       ci32 = ci; end
    endcase
  endtask

  task automatic scramble(int g);
    drive(g, 1'b0, $urandom, $urandom, 1'($urandom));
  endtask

  task automatic check_result(int g, int d, logic [31:0] a, logic [31:0] b, logic ci);
    check($sformatf("le g%0d d%0d a=%0h b=%0h ci=%0b", g, d, a, b, ci),
          le_g[g][d], ref_le(wid[g], sgn[g][d], a, b, ci));
`ifdef ALEB_SEQ_EQ_EN
    check($sformatf("eq g%0d d%0d a=%0h b=%0h", g, d, a, b), eq_g[g][d], ref_eq(wid[g], a, b));
`endif
  endtask

  // One accepted START, then a cycle-by-cycle check of BUSY/DONE timing and the result.
  task automatic compare(int g, logic [31:0] a, logic [31:0] b, logic ci);
    int nmax;
    nmax = 0;
    for (int d = 0; d < ndut[g]; d++) if (ncyc[g][d] > nmax) nmax = ncyc[g][d];
    @(negedge clk);
    drive(g, 1'b1, a, b, ci);
    @(posedge clk); #1;
    for (int d = 0; d < ndut[g]; d++) check($sformatf("busy_e0 g%0d d%0d", g, d), busy_g[g][d], 1'b1);
    scramble(g);
    for (int k = 1; k <= nmax; k++) begin
      @(posedge clk); #1;
      for (int d = 0; d < ndut[g]; d++) begin
        check($sformatf("done g%0d d%0d k%0d", g, d, k), done_g[g][d], k == ncyc[g][d]);
        check($sformatf("busy g%0d d%0d k%0d", g, d, k), busy_g[g][d], k < ncyc[g][d]);
        if (k == ncyc[g][d]) check_result(g, d, a, b, ci);
      end
      scramble(g);
    end
    @(posedge clk); #1;
    for (int d = 0; d < ndut[g]; d++) check($sformatf("done_clr g%0d d%0d", g, d), done_g[g][d], 1'b0);
  endtask

  task automatic check_idle_reset(int g);
    for (int d = 0; d < ndut[g]; d++) begin
      check($sformatf("rst_busy g%0d d%0d", g, d), busy_g[g][d], 1'b0);
      check($sformatf("rst_done g%0d d%0d", g, d), done_g[g][d], 1'b0);
      check($sformatf("rst_le g%0d d%0d", g, d), le_g[g][d], 1'b0);
`ifdef ALEB_SEQ_EQ_EN
      check($sformatf("rst_eq g%0d d%0d", g, d), eq_g[g][d], 1'b0);
`endif
    end
  endtask

  initial begin
    logic [31:0] a0, b0, a1, b1;
    logic        c0, c1;

    rst = 1'b1;
    for (int g = 0; g < 3; g++) drive(g, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) check_idle_reset(g);
    @(negedge clk);
    rst = 1'b0;

    // Exhaustive 2-bit case, N=1
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int c = 0; c < 2; c++)
          compare(0, 32'(a), 32'(b), 1'(c));

    // Equal operands with both carry-ins, then the signed/unsigned corner cases
    compare(1, 32'h1234, 32'h1234, 1'b1);
    compare(1, 32'h1234, 32'h1234, 1'b0);
    compare(1, 32'hFFFF, 32'h0000, 1'b1);
    compare(1, 32'h7FFF, 32'h8000, 1'b1);
    compare(1, 32'h8000, 32'h7FFF, 1'b0);

    // START held high with operands changing every clock
    @(negedge clk);
    a0 = $urandom; b0 = $urandom; c0 = 1'($urandom);
    drive(1, 1'b1, a0, b0, c0);
    @(posedge clk); #1;
    for (int k = 1; k <= 8; k++) begin
      for (int d = 0; d < 2; d++) check($sformatf("hold_busy d%0d k%0d", d, k - 1), busy_g[1][d], 1'b1);
      drive(1, 1'b1, $urandom, $urandom, 1'($urandom));
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) check($sformatf("hold_done d%0d k%0d", d, k), done_g[1][d], k == 8);
    end
    for (int d = 0; d < 2; d++) begin
      check($sformatf("hold_busy_end d%0d", d), busy_g[1][d], 1'b0);
      check_result(1, d, a0, b0, c0);
    end
    a1 = $urandom; b1 = $urandom; c1 = 1'($urandom);
    drive(1, 1'b1, a1, b1, c1);
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reaccept_busy d%0d", d), busy_g[1][d], 1'b1);
      check($sformatf("reaccept_done d%0d", d), done_g[1][d], 1'b0);
    end
    scramble(1);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) check($sformatf("second_done d%0d k%0d", d, k), done_g[1][d], k == 8);
      scramble(1);
    end
    for (int d = 0; d < 2; d++) check_result(1, d, a1, b1, c1);

    // Reset landing on the 4th RUN clock, with idle DUTs holding LE=1
    compare(2, 32'h5, 32'h5, 1'b1);
    @(negedge clk);
    drive(1, 1'b1, 32'h1, 32'h2, 1'b1);
    @(posedge clk); #1;
    scramble(1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle_reset(1);
    check_idle_reset(2);
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) check($sformatf("no_done_after_rst d%0d k%0d", d, k), done_g[1][d], 1'b0);
    end
    compare(1, 32'h1, 32'h2, 1'b1);

    // Random 16-bit and 32-bit vectors, with a share of equal operands
    for (int i = 0; i < 200; i++) begin
      a0 = $urandom; b0 = ($urandom_range(3) == 0) ? a0 : $urandom;
      compare(1, a0, b0, 1'($urandom));
    end
    for (int i = 0; i < 1000; i++) begin
      a0 = $urandom; b0 = ($urandom_range(3) == 0) ? a0 : $urandom;
      compare(2, a0, b0, 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
